sram_1rw1r_masked_model: RTL and testbench
==========================================

SRAM_1RW1R_MASKED_MODEL -- requirements
Module: sram_1rw1r_masked_model

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width in bits; it SHALL be a multiple of 8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 13, address width of both ports.
REQ-003 SHALL provide parameter RAM_DEPTH, default 8192, number of words; valid range 1..2^ADDR_WIDTH.
REQ-004 SHALL provide parameter NUM_WMASKS, default DATA_WIDTH/8, one write-enable bit per byte.
REQ-005 SHALL provide port clk0, input, 1 bit: the single clock for both ports; all logic is rising-edge.
REQ-006 SHALL provide port rst0, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide port csb0, input, 1 bit: active-low select for port 0, which is read/write.
REQ-008 SHALL provide port web0, input, 1 bit: active-low write enable for port 0.
REQ-009 SHALL provide port wmask0, input, NUM_WMASKS bits: per-byte write enable; bit i covers din0[8i+7:8i].
REQ-010 SHALL provide port addr0, input, ADDR_WIDTH bits: port 0 address.
REQ-011 SHALL provide port din0, input, DATA_WIDTH bits: port 0 write data.
REQ-012 SHALL provide port dout0, output, DATA_WIDTH bits: port 0 read data.
REQ-013 SHALL provide port dvalid0, output, 1 bit: dout0 holds fresh read data.
REQ-014 SHALL provide port csb1, input, 1 bit: active-low select for port 1, which is read-only.
REQ-015 SHALL provide port addr1, input, ADDR_WIDTH bits: port 1 address.
REQ-016 SHALL provide port dout1, output, DATA_WIDTH bits: port 1 read data.
REQ-017 SHALL provide port dvalid1, output, 1 bit: dout1 holds fresh read data.
REQ-018 SHALL provide port addr_err, output, 1 bit: sticky flag for an out-of-range access.

Function
REQ-019 Port 0 write:
- Occurs when csb0=0 and web0=0 at a rising edge.
- Updates only the bytes whose wmask0 bit is 1; all other bytes keep their value.
- wmask0=0 leaves the word unchanged.
REQ-020 Port 0 read:
- Occurs when csb0=0 and web0=1 at edge N.
- dout0 is loaded with mem[addr0] at edge N; dvalid0=1 during cycle N+1.
- Read latency is exactly 1 cycle.
REQ-021 Port 0 write cycle: dvalid0=0 and dout0 holds its previous value.
REQ-022 Port 1 read:
- Occurs when csb1=0 at edge N.
- dout1 is loaded with mem[addr1] at edge N; dvalid1=1 during cycle N+1.
REQ-023 Deselected port (csb=1): its dvalid=0 the next cycle and its dout holds its last value.
REQ-024 Back-to-back reads SHALL sustain one result per cycle per port, with no bubbles.
REQ-025 Address at or above RAM_DEPTH:
- A write is dropped.
- A read returns all-zeros with dvalid=1.
- addr_err is set from the next cycle and stays set until reset.
REQ-026 Collision: port 0 write and port 1 read to the same valid address on the same edge.
- Port 1 read data is defined by REQ-031/REQ-032.
- The port 0 write always completes.
REQ-027 Port 0 read and port 1 read to the same address on the same edge SHALL both return the same stored word.

Reset
REQ-028 When rst0=1 at a rising edge:
- dout0, dout1 = 0.
- dvalid0, dvalid1, addr_err = 0.
- Any port 0 write in that cycle is suppressed.
REQ-029 Memory contents SHALL NOT be cleared by reset and are uninitialised (X) until first written.
REQ-030 An access issued on the first edge after rst0 deasserts SHALL be honoured normally.

Configuration
REQ-031 With SRAM_BYPASS_EN defined, a collision returns the post-write merged word on dout1: new bytes where wmask0=1, old bytes elsewhere.
REQ-032 With SRAM_BYPASS_EN undefined, a collision returns the pre-write word on dout1 (read-before-write).

Verification
REQ-033 Masked write, then read:
- Write 0xFFFFFFFF to addr 5 with wmask0=1111.
- Write 0x12345678 to addr 5 with wmask0=0101.
- Read addr 5 -> dout0=0xFF34FF78, dvalid0=1 exactly 1 cycle after the read edge.
REQ-034 Dual-port streaming:
- Preload addr 0..3 with 0xA0..0xA3.
- Port 1 reads 0,1,2,3 on consecutive edges -> dout1=0xA0,0xA1,0xA2,0xA3 on consecutive cycles; dvalid1 stays high throughout.
REQ-035 Collision:
- addr 7 holds 0x11111111.
- Same edge: port 0 writes 0x22222222 with wmask0=1111; port 1 reads addr 7.
- dout1=0x22222222 with SRAM_BYPASS_EN, 0x11111111 without.
- A later read of addr 7 returns 0x22222222 in both builds.
REQ-036 Out-of-range access with RAM_DEPTH=6000:
- Write to addr 6000 -> addr_err=1.
- Read addr 6000 -> dout0=0, dvalid0=1.
- A rst0 pulse clears addr_err.
REQ-037 Reset during a write:
- rst0=1 on the same edge as a write of 0xDEADBEEF to addr 9.
- A later read of addr 9 returns the old value.
- dout0, dvalid0, dout1, dvalid1 are 0 the cycle after reset.

Source files
------------

// File: rtl/sram_1rw1r_masked_model.sv
`default_nettype none
//==============================================================================
// Module   : sram_1rw1r_masked_model
// Purpose  : Behavioural 1RW+1R SRAM with byte write masks, 1-cycle reads,
//            per-port data-valid flags and a sticky out-of-range flag.
//            Define SRAM_BYPASS_EN to forward same-address port 0 write data
//            to port 1 (otherwise port 1 sees read-before-write data).
// Revision : 1.0 - initial release
//==============================================================================
module sram_1rw1r_masked_model #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int RAM_DEPTH  = 8192,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_dvalid0;
    logic                  r_dvalid1;
    logic                  r_addr_err;

    logic                  w_wr0;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_addr0_ok;
    logic                  w_addr1_ok;
    logic [DATA_WIDTH-1:0] w_mem0;
    logic [DATA_WIDTH-1:0] w_mem1;
    logic [DATA_WIDTH-1:0] w_rdata1;

    assign w_wr0      = !csb0 && !web0;
    assign w_rd0      = !csb0 &&  web0;
    assign w_rd1      = !csb1;
    assign w_addr0_ok = {1'b0, addr0} < c_DEPTH;
    assign w_addr1_ok = {1'b0, addr1} < c_DEPTH;
    assign w_mem0     = w_addr0_ok ? r_mem[addr0] : '0;
    assign w_mem1     = w_addr1_ok ? r_mem[addr1] : '0;

`ifdef SRAM_BYPASS_EN
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_collide = w_wr0 && w_addr1_ok && (addr0 == addr1);

    // Post-write view of the colliding word: new bytes where masked in.
    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_merge
        assign w_merged[8*g +: 8] = wmask0[g] ? din0[8*g +: 8] : w_mem1[8*g +: 8];
    end

    assign w_rdata1 = w_collide ? w_merged : w_mem1;
`else
    assign w_rdata1 = w_mem1;
`endif

    // Array has no reset: contents survive rst0 and start out undefined.
    always_ff @(posedge clk0) begin
        if (!rst0 && w_wr0 && w_addr0_ok) begin
            for (int b = 0; b < NUM_WMASKS; b++) begin
                if (wmask0[b]) begin
                    r_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_dout0    <= '0;
            r_dout1    <= '0;
            r_dvalid0  <= 1'b0;
            r_dvalid1  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_dvalid0 <= w_rd0;
            r_dvalid1 <= w_rd1;
            if (w_rd0) begin
                r_dout0 <= w_mem0;
            end
            if (w_rd1) begin
                r_dout1 <= w_rdata1;
            end
            if ((!csb0 && !w_addr0_ok) || (!csb1 && !w_addr1_ok)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign dout0    = r_dout0;
    assign dout1    = r_dout1;
    assign dvalid0  = r_dvalid0;
    assign dvalid1  = r_dvalid1;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_masked_model.sv
`default_nettype none
//==============================================================================
// Module   : tb_sram_1rw1r_masked_model
// Purpose  : Directed self-checking bench for sram_1rw1r_masked_model
//            (RAM_DEPTH=6000); SRAM_BYPASS_EN selects the collision result.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sram_1rw1r_masked_model;

    localparam int c_DW = 32;
    localparam int c_AW = 13;
    localparam int c_NM = c_DW / 8;

    logic            clk0 = 1'b0;
    logic            rst0;
    logic            csb0;
    logic            web0;
    logic [c_NM-1:0] wmask0;
    logic [c_AW-1:0] addr0;
    logic [c_DW-1:0] din0;
    logic [c_DW-1:0] dout0;
    logic            dvalid0;
    logic            csb1;
    logic [c_AW-1:0] addr1;
    logic [c_DW-1:0] dout1;
    logic            dvalid1;
    logic            addr_err;

    int n_checks = 0;
    int n_errors = 0;

    sram_1rw1r_masked_model #(
        .DATA_WIDTH(c_DW),
        .ADDR_WIDTH(c_AW),
        .RAM_DEPTH (6000),
        .NUM_WMASKS(c_NM)
    ) dut (
        .clk0    (clk0),
        .rst0    (rst0),
        .csb0    (csb0),
        .web0    (web0),
        .wmask0  (wmask0),
        .addr0   (addr0),
        .din0    (din0),
        .dout0   (dout0),
        .dvalid0 (dvalid0),
        .csb1    (csb1),
        .addr1   (addr1),
        .dout1   (dout1),
        .dvalid1 (dvalid1),
        .addr_err(addr_err)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;
    endtask

    task automatic wr0(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d, input logic [c_NM-1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic rd0(input logic [c_AW-1:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = '0;
    endtask

    task automatic rd1(input logic [c_AW-1:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    initial begin
        logic [c_DW-1:0] exp_coll;
`ifdef SRAM_BYPASS_EN
        exp_coll = 32'h2222_2222;
`else
        exp_coll = 32'h1111_1111;
`endif
        idle();
        rst0 = 1'b1;
        tick();
        chk("rst_dout0",    dout0,    '0);
        chk("rst_dout1",    dout1,    '0);
        chk("rst_dvalid0",  {31'b0, dvalid0},  32'd0);
        chk("rst_dvalid1",  {31'b0, dvalid1},  32'd0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);

        // First edge after reset: full write, then partial masked write
        rst0 = 1'b0;
        wr0(13'd5, 32'hFFFF_FFFF, 4'b1111);
        tick();
        chk("wr_dvalid0", {31'b0, dvalid0}, 32'd0);
        wr0(13'd5, 32'h1234_5678, 4'b0101);
        tick();
        rd0(13'd5);
        tick();
        chk("mask_dout0",   dout0, 32'hFF34_FF78);
        chk("mask_dvalid0", {31'b0, dvalid0}, 32'd1);
        wr0(13'd5, 32'h0000_0000, 4'b0000);
        tick();
        chk("wrcyc_hold_dout0", dout0, 32'hFF34_FF78);
        idle();
        tick();
        chk("desel_dvalid0", {31'b0, dvalid0}, 32'd0);
        chk("desel_dout0",   dout0, 32'hFF34_FF78);
        rd0(13'd5);
        tick();
        chk("nomask_dout0", dout0, 32'hFF34_FF78);

        // Preload and stream port 1 reads with no bubbles
        for (int i = 0; i < 4; i++) begin
            wr0(13'(i), 32'hA0 + 32'(i), 4'b1111);
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd1(13'(i));
            tick();
            chk("stream_dout1",   dout1, 32'hA0 + 32'(i));
            chk("stream_dvalid1", {31'b0, dvalid1}, 32'd1);
        end
        rd0(13'd3);
        rd1(13'd3);
        tick();
        chk("same_addr_dout0", dout0, 32'hA3);
        chk("same_addr_dout1", dout1, 32'hA3);
        idle();
        tick();
        chk("desel_dvalid1", {31'b0, dvalid1}, 32'd0);
        chk("desel_dout1",   dout1, 32'hA3);

        // Collision on addr 7
        wr0(13'd7, 32'h1111_1111, 4'b1111);
        tick();
        wr0(13'd7, 32'h2222_2222, 4'b1111);
        rd1(13'd7);
        tick();
        chk("coll_dout1", dout1, exp_coll);
        idle();
        rd0(13'd7);
        tick();
        chk("coll_after_dout0", dout0, 32'h2222_2222);

        // Last valid word, then out-of-range access
        wr0(13'd5999, 32'h5999_0001, 4'b1111);
        tick();
        chk("edge_no_err", {31'b0, addr_err}, 32'd0);
        rd0(13'd5999);
        tick();
        chk("edge_dout0", dout0, 32'h5999_0001);
        wr0(13'd6000, 32'hCAFE_F00D, 4'b1111);
        tick();
        chk("oor_wr_err", {31'b0, addr_err}, 32'd1);
        rd0(13'd6000);
        tick();
        chk("oor_rd_dout0",   dout0, 32'h0);
        chk("oor_rd_dvalid0", {31'b0, dvalid0}, 32'd1);
        idle();
        tick();
        chk("oor_sticky", {31'b0, addr_err}, 32'd1);

        // Reset while writing addr 9: write must be dropped
        wr0(13'd9, 32'h0BAD_0009, 4'b1111);
        tick();
        rd1(13'd9);
        tick();
        chk("pre_rst_dout1", dout1, 32'h0BAD_0009);
        rst0 = 1'b1;
        wr0(13'd9, 32'hDEAD_BEEF, 4'b1111);
        rd1(13'd1);
        tick();
        chk("rstw_dout0",    dout0, 32'h0);
        chk("rstw_dout1",    dout1, 32'h0);
        chk("rstw_dvalid0",  {31'b0, dvalid0},  32'd0);
        chk("rstw_dvalid1",  {31'b0, dvalid1},  32'd0);
        chk("rstw_addr_err", {31'b0, addr_err}, 32'd0);
        rst0 = 1'b0;
        idle();
        rd0(13'd9);
        tick();
        chk("rstw_old_dout0",   dout0, 32'h0BAD_0009);
        chk("rstw_old_dvalid0", {31'b0, dvalid0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
